// File: rtl/encoder_negedge.sv
// Binary-to-temporal encoder: each accepted value v becomes a line held high for
// (MAX_VALUE - v) cycles inside a MAX_VALUE+1 cycle window, preceded by a decoder reset pulse.
module encoder_negedge #(
    parameter int MAX_VALUE  = 8,
    parameter int NUM_LINES  = 4,
    parameter int GAP_CYCLES = 1,
    localparam int VW = $clog2(MAX_VALUE + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_LINES*VW-1:0] in_values,
    output logic [NUM_LINES-1:0]    outgoing_lines,
    output logic                    window_reset_out,
    output logic                    window_done,
    output logic                    clamp_error
);

    localparam logic [VW-1:0] MAX_V = VW'(MAX_VALUE);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        DRIVE,
        GAP
    } state_t;

    state_t         state;
    logic [VW-1:0]  t;
    logic [VW-1:0]  t_inc;
    logic [GW-1:0]  gap_cnt;
    logic [VW-1:0]  high_len   [NUM_LINES];
    logic [VW-1:0]  accept_len [NUM_LINES];
    logic           any_clamp;

    assign in_ready = (state == IDLE);
    assign t_inc    = t + VW'(1);

    // High duration per line; out-of-range values clamp to MAX_VALUE, i.e. a zero-length pulse.
    always_comb begin
        any_clamp = 1'b0;
        for (int i = 0; i < NUM_LINES; i++) begin
            accept_len[i] = '0;
            if (in_values[i*VW +: VW] > MAX_V) begin
                any_clamp = 1'b1;
            end else begin
                accept_len[i] = MAX_V - in_values[i*VW +: VW];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (state == IDLE && in_valid) begin
            high_len <= accept_len;
        end
    end

    // Outputs are computed from the state being entered, so they line up with that state's cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            t                <= '0;
            gap_cnt          <= '0;
            outgoing_lines   <= '0;
            window_reset_out <= 1'b0;
            window_done      <= 1'b0;
            clamp_error      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    outgoing_lines <= '0;
                    window_done    <= 1'b0;
                    if (in_valid) begin
                        state            <= PRIME;
                        window_reset_out <= 1'b1;
                        clamp_error      <= any_clamp;
                    end else begin
                        window_reset_out <= 1'b0;
                        clamp_error      <= 1'b0;
                    end
                end
                PRIME: begin
                    state            <= DRIVE;
                    t                <= '0;
                    window_reset_out <= 1'b0;
                    clamp_error      <= 1'b0;
                    window_done      <= (MAX_V == '0);
                    for (int i = 0; i < NUM_LINES; i++) begin
                        outgoing_lines[i] <= (high_len[i] != '0);
                    end
                end
                DRIVE: begin
                    if (t == MAX_V) begin
                        t              <= '0;
                        outgoing_lines <= '0;
                        window_done    <= 1'b0;
                        if (GAP_CYCLES > 0) begin
                            state   <= GAP;
                            gap_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        t           <= t_inc;
                        window_done <= (t_inc == MAX_V);
                        for (int i = 0; i < NUM_LINES; i++) begin
                            outgoing_lines[i] <= (t_inc < high_len[i]);
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_negedge.sv
// Scoreboard bench for encoder_negedge: stimulus pushes expected pulse lengths and decoded
// values, a monitor reconstructs each window from the lines and compares.
module tb_encoder_negedge;

    localparam int MAXV = 8;
    localparam int NL   = 4;
    localparam int VW   = 4;
    localparam int IW   = NL * VW;

    typedef struct packed {
        logic [NL-1:0][7:0] high;
        logic [NL-1:0][7:0] value;
        logic               clamp;
    } exp_t;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_values;
    logic [NL-1:0] outgoing_lines;
    logic          window_reset_out;
    logic          window_done;
    logic          clamp_error;

    logic          valid0;
    logic          ready0;
    logic [IW-1:0] vals0;
    logic [NL-1:0] lines0;
    logic          wro0;
    logic          done0;
    logic          clamp0;

    exp_t exp_q[$];
    int   tests;
    int   fails;
    int   cyc;
    bit   mon_en;
    bit   mon_busy;

    encoder_negedge #(.MAX_VALUE(MAXV), .NUM_LINES(NL), .GAP_CYCLES(1)) u_dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_values(in_values), .outgoing_lines(outgoing_lines),
        .window_reset_out(window_reset_out), .window_done(window_done), .clamp_error(clamp_error)
    );

    encoder_negedge #(.MAX_VALUE(MAXV), .NUM_LINES(NL), .GAP_CYCLES(0)) u_dut_nogap (
        .clock(clock), .reset(reset), .in_valid(valid0), .in_ready(ready0),
        .in_values(vals0), .outgoing_lines(lines0),
        .window_reset_out(wro0), .window_done(done0), .clamp_error(clamp0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish (actual timeout, required completion)");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [IW-1:0] randVals();
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < NL; i++) begin
            case ($urandom_range(0, 3))
                0:       r[i*VW +: VW] = '0;
                1:       r[i*VW +: VW] = VW'(MAXV);
                2:       r[i*VW +: VW] = VW'($urandom_range(MAXV + 1, 15));
                default: r[i*VW +: VW] = VW'($urandom_range(0, MAXV));
            endcase
        end
        return r;
    endfunction

    // Drives one cycle of input; on a transfer the reference response is queued.
    task automatic applyStimulus(input logic v, input logic [IW-1:0] vals, output bit accepted,
                                 output int acc_cyc);
        exp_t e;
        int   raw;
        int   cv;
        @(negedge clock);
        in_valid  = v;
        in_values = vals;
        accepted  = v && in_ready;
        acc_cyc   = cyc;
        if (accepted) begin
            e = '0;
            for (int i = 0; i < NL; i++) begin
                raw = int'(vals[i*VW +: VW]);
                cv  = (raw > MAXV) ? MAXV : raw;
                if (raw > MAXV) e.clamp = 1'b1;
                e.value[i] = 8'(cv);
                e.high[i]  = 8'(MAXV - cv);
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic sendVector(input logic [IW-1:0] vals);
        bit acc;
        int c;
        int n;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            applyStimulus(1'b1, vals, acc, c);
            n++;
        end
        if (!acc) checkOutput("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        @(negedge clock);
        in_valid = 1'b0;
        while ((exp_q.size() != 0 || mon_busy) && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        checkOutput("drain_timeout", int'(waited < 100), 1);
        repeat (2) @(negedge clock);
    endtask

    // Monitor: rebuilds each window from the lines and compares against the queued expectation.
    initial begin : monitor
        exp_t e;
        int   hcnt[NL];
        bit   fell[NL];
        int   bad[NL];
        mon_busy = 1'b0;
        forever begin
            @(negedge clock);
            if (mon_en && !reset) begin
                if (window_reset_out) begin
                    mon_busy = 1'b1;
                    checkOutput("prime_lines_low", int'(outgoing_lines), 0);
                    checkOutput("prime_in_ready", int'(in_ready), 0);
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_window", 1, 0);
                        e = '0;
                    end else begin
                        e = exp_q.pop_front();
                    end
                    checkOutput("clamp_error", int'(clamp_error), int'(e.clamp));
                    for (int i = 0; i < NL; i++) begin
                        hcnt[i] = 0;
                        fell[i] = 1'b0;
                        bad[i]  = 0;
                    end
                    for (int t = 0; t <= MAXV; t++) begin
                        @(negedge clock);
                        checkOutput("drive_window_done", int'(window_done), int'(t == MAXV));
                        checkOutput("drive_in_ready", int'(in_ready), 0);
                        checkOutput("drive_window_reset", int'(window_reset_out), 0);
                        for (int i = 0; i < NL; i++) begin
                            if (outgoing_lines[i]) begin
                                if (fell[i]) bad[i]++;
                                hcnt[i]++;
                            end else begin
                                fell[i] = 1'b1;
                            end
                        end
                    end
                    for (int i = 0; i < NL; i++) begin
                        checkOutput($sformatf("line%0d_high_cycles", i), hcnt[i], int'(e.high[i]));
                        checkOutput($sformatf("line%0d_rise_after_fall", i), bad[i], 0);
                        checkOutput($sformatf("line%0d_decoded", i), MAXV - hcnt[i], int'(e.value[i]));
                    end
                    mon_busy = 1'b0;
                end else begin
                    checkOutput("idle_lines_low", int'(outgoing_lines), 0);
                    checkOutput("idle_window_done", int'(window_done), 0);
                    checkOutput("idle_clamp_error", int'(clamp_error), 0);
                end
            end
        end
    end

    initial begin : stimulus
        bit acc;
        int c;
        int acc_cycles[$];
        int n;
        int dones;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_values = '0;
        valid0    = 1'b0;
        vals0     = '0;
        mon_en    = 1'b0;
        cyc       = 0;
        tests     = 0;
        fails     = 0;

        repeat (3) @(negedge clock);
        checkOutput("reset_lines", int'(outgoing_lines), 0);
        checkOutput("reset_window_reset", int'(window_reset_out), 0);
        checkOutput("reset_window_done", int'(window_done), 0);
        checkOutput("reset_clamp_error", int'(clamp_error), 0);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("ready_after_reset", int'(in_ready), 1);
        mon_en = 1'b1;

        // Channel 0 sits in the low nibble: values {5,0,8,3}.
        sendVector({4'd3, 4'd8, 4'd0, 4'd5});
        drain();
        sendVector({4'd0, 4'd0, 4'd0, 4'd15});
        drain();

        // Back-to-back with in_valid held and in_values changing every cycle.
        n = 0;
        while (acc_cycles.size() < 4 && n < 100) begin
            applyStimulus(1'b1, randVals(), acc, c);
            if (acc) acc_cycles.push_back(c);
            n++;
        end
        checkOutput("b2b_accept_count", acc_cycles.size(), 4);
        for (int k = 1; k < acc_cycles.size(); k++) begin
            checkOutput("b2b_accept_spacing", acc_cycles[k] - acc_cycles[k-1], 12);
        end
        drain();

        repeat (400) applyStimulus(1'(($urandom_range(0, 2) == 0)), randVals(), acc, c);
        drain();
        checkOutput("queue_empty", exp_q.size(), 0);

        // Reset in the middle of a window at DRIVE t=2.
        mon_en = 1'b0;
        sendVector('0);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("pre_reset_lines_high", int'(outgoing_lines), 15);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("abort_lines_low", int'(outgoing_lines), 0);
        checkOutput("abort_window_done", int'(window_done), 0);
        checkOutput("abort_in_ready", int'(in_ready), 1);
        reset = 1'b0;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (window_done || outgoing_lines != '0) dones++;
        end
        checkOutput("abort_stays_quiet", dones, 0);
        checkOutput("ready_after_abort", int'(in_ready), 1);

        // Zero-gap instance: accept possible the cycle right after window_done.
        @(negedge clock);
        checkOutput("nogap_ready_initial", int'(ready0), 1);
        valid0 = 1'b1;
        vals0  = randVals();
        for (int r = 0; r < 2; r++) begin
            for (int k = 1; k <= 11; k++) begin
                @(negedge clock);
                vals0 = randVals();
                if (k == 1) checkOutput("nogap_prime", int'(wro0), 1);
                checkOutput("nogap_ready", int'(ready0), int'(k == 11));
                checkOutput("nogap_done", int'(done0), int'(k == 10));
            end
        end
        valid0 = 1'b0;
        repeat (2) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
